mac_lookup_ctrl: RTL and testbench

Per-port front end for the MAC learning table: it parses the destination and source addresses from an ingress frame's header byte stream and folds each 48-bit address into a table index. In one cycle it learns SA→ingress port and looks up DA, then hands a forwarding decision to the switch fabric over a valid/ready handshake. It sits between a port receiver and the shared MAC table; it drives the table's write and lookup inputs and consumes its registered port output.

---
 rtl/switch_pkg.sv | 27 ++
 rtl/mac_hash_fold.sv | 24 ++
 rtl/mac_lookup_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_mac_lookup_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared switch definitions: MAC/header sizes, lookup FSM state encoding and
// small helpers used by the MAC lookup front end and the table scanner.
package switch_pkg;

   localparam int MAC_W     = 48;
   localparam int HDR_BYTES = 12;
   localparam int HDR_W     = 8 * HDR_BYTES;
   localparam int STAT_W    = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HDR    = 3'd1,
      ISSUE  = 3'd2,
      WAIT   = 3'd3,
      DECIDE = 3'd4
   } state_t;

   // Group bit is the LSB of the first address byte on the wire.
   function automatic logic is_mcast(input logic [7:0] first_byte);
      return first_byte[0];
   endfunction

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
      return (value == {STAT_W{1'b1}}) ? value : value + 1'b1;
   endfunction

endpackage

// File: rtl/mac_hash_fold.sv
// Folds a 48-bit MAC address into an IW-bit table index by XORing IW-bit
// chunks (LSB chunk first, top chunk zero-padded). Purely combinational.
module mac_hash_fold
   import switch_pkg::*;
#(
   parameter int IW = 10
) (
   input  logic [MAC_W-1:0] i_mac,
   output logic [IW-1:0]    o_idx
);

   localparam int NCH = (MAC_W + IW - 1) / IW;

   logic [NCH*IW-1:0] w_padded;

   always_comb begin
      w_padded = (NCH*IW)'(i_mac);
      o_idx    = '0;
      for (int c = 0; c < NCH; c++) begin
         o_idx = o_idx ^ w_padded[c*IW +: IW];
      end
   end

endmodule

// File: rtl/mac_lookup_ctrl.sv
// Per-port MAC learn/lookup front end: parses DA/SA, drives the MAC table and
// issues one forwarding decision per frame. Statistics counters: MAC_CTRL_STATS_EN.
module mac_lookup_ctrl
   import switch_pkg::*;
#(
   parameter  int pPORT_NUM      = 4,
   parameter  int pMAC_MEM_DEPTH = 1024,
   localparam int PW             = $clog2(pPORT_NUM),
   localparam int IW             = $clog2(pMAC_MEM_DEPTH)
) (
   input  logic              iclk,
   input  logic              i_rst,
   input  logic              i_valid,
   input  logic [7:0]        i_data,
   input  logic              i_sof,
   input  logic              i_eof,
   input  logic [PW-1:0]     i_src_port,
   output logic              o_write_enable,
   output logic [PW-1:0]     o_port_num,
   output logic [IW-1:0]     o_MAC_SA,
   output logic [IW-1:0]     o_MAC_DA,
   input  logic [PW-1:0]     i_table_port,
   output logic              o_fwd_valid,
   input  logic              i_fwd_ready,
   output logic [PW-1:0]     o_fwd_port,
   output logic              o_fwd_flood,
   output logic              o_fwd_filter,
   output logic              o_drop,
   output logic [STAT_W-1:0] o_stat_learn,
   output logic [STAT_W-1:0] o_stat_flood,
   output logic [STAT_W-1:0] o_stat_drop
);

   // Decision handshake: o_fwd_valid stays high with o_fwd_port/flood/filter
   // frozen until the cycle i_fwd_ready is sampled high; that edge is the transfer.

   localparam logic [2:0] S_IDLE   = 3'(IDLE);
   localparam logic [2:0] S_HDR    = 3'(HDR);
   localparam logic [2:0] S_ISSUE  = 3'(ISSUE);
   localparam logic [2:0] S_WAIT   = 3'(WAIT);
   localparam logic [2:0] S_DECIDE = 3'(DECIDE);
   localparam logic [3:0] LAST_HDR_BYTE = 4'(HDR_BYTES - 1);

   logic [2:0]       r_state;
   logic [HDR_W-1:0] r_hdr;
   logic [3:0]       r_cnt;
   logic [PW-1:0]    r_src_port;
   logic             r_drop;
   logic [PW-1:0]    r_fwd_port;
   logic             r_fwd_flood;
   logic             r_fwd_filter;

   logic [MAC_W-1:0] w_da;
   logic [MAC_W-1:0] w_sa;
   logic [IW-1:0]    w_da_idx;
   logic [IW-1:0]    w_sa_idx;
   logic             w_in_issue;
   logic             w_busy;
   logic             w_start;

   assign w_da       = r_hdr[HDR_W-1 -: MAC_W];
   assign w_sa       = r_hdr[MAC_W-1:0];
   assign w_in_issue = (r_state == S_ISSUE);
   assign w_busy     = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_DECIDE);
   assign w_start    = i_valid && i_sof;

   mac_hash_fold #(.IW(IW)) u_hash_da (
      .i_mac (w_da),
      .o_idx (w_da_idx)
   );

   mac_hash_fold #(.IW(IW)) u_hash_sa (
      .i_mac (w_sa),
      .o_idx (w_sa_idx)
   );

   always_ff @(posedge iclk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_hdr        <= '0;
         r_cnt        <= '0;
         r_src_port   <= '0;
         r_drop       <= 1'b0;
         r_fwd_port   <= '0;
         r_fwd_flood  <= 1'b0;
         r_fwd_filter <= 1'b0;
      end else begin
         r_drop <= w_busy && w_start;
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_hdr      <= HDR_W'(i_data);
                  r_src_port <= i_src_port;
                  r_cnt      <= 4'd1;
                  if (i_eof) begin
                     r_drop <= 1'b1;
                  end else begin
                     r_state <= S_HDR;
                  end
               end
            end
            S_HDR: begin
               if (i_valid && i_sof) begin
                  // New frame overrides a partial header; the old one is dropped.
                  r_hdr      <= HDR_W'(i_data);
                  r_src_port <= i_src_port;
                  r_cnt      <= 4'd1;
                  r_drop     <= 1'b1;
                  if (i_eof) begin
                     r_state <= S_IDLE;
                  end
               end else if (i_valid) begin
                  r_hdr <= {r_hdr[HDR_W-9:0], i_data};
                  r_cnt <= r_cnt + 4'd1;
                  if (r_cnt == LAST_HDR_BYTE) begin
                     r_state <= S_ISSUE;
                  end else if (i_eof) begin
                     r_state <= S_IDLE;
                     r_drop  <= 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               // Table data for the DA index issued last cycle is valid now.
               if (is_mcast(w_da[MAC_W-1 -: 8])) begin
                  r_fwd_flood  <= 1'b1;
                  r_fwd_port   <= '0;
                  r_fwd_filter <= 1'b0;
               end else begin
                  r_fwd_flood  <= 1'b0;
                  r_fwd_port   <= i_table_port;
                  r_fwd_filter <= (i_table_port == r_src_port);
               end
               r_state <= S_DECIDE;
            end
            S_DECIDE: begin
               if (i_fwd_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_write_enable = w_in_issue && !is_mcast(w_sa[MAC_W-1 -: 8]);
   assign o_port_num     = w_in_issue ? r_src_port : '0;
   assign o_MAC_SA       = w_in_issue ? w_sa_idx : '0;
   assign o_MAC_DA       = w_in_issue ? w_da_idx : '0;
   assign o_fwd_valid    = (r_state == S_DECIDE);
   assign o_fwd_port     = r_fwd_port;
   assign o_fwd_flood    = r_fwd_flood;
   assign o_fwd_filter   = r_fwd_filter;
   assign o_drop         = r_drop;

`ifdef MAC_CTRL_STATS_EN
   logic [STAT_W-1:0] r_stat_learn;
   logic [STAT_W-1:0] r_stat_flood;
   logic [STAT_W-1:0] r_stat_drop;

   always_ff @(posedge iclk) begin
      if (i_rst) begin
         r_stat_learn <= '0;
         r_stat_flood <= '0;
         r_stat_drop  <= '0;
      end else begin
         if (o_write_enable) begin
            r_stat_learn <= sat_inc(r_stat_learn);
         end
         if (o_fwd_valid && i_fwd_ready && r_fwd_flood) begin
            r_stat_flood <= sat_inc(r_stat_flood);
         end
         if (r_drop) begin
            r_stat_drop <= sat_inc(r_stat_drop);
         end
      end
   end

   assign o_stat_learn = r_stat_learn;
   assign o_stat_flood = r_stat_flood;
   assign o_stat_drop  = r_stat_drop;
`else
   assign o_stat_learn = '0;
   assign o_stat_flood = '0;
   assign o_stat_drop  = '0;
`endif

endmodule

// File: tb/tb_mac_lookup_ctrl.sv
// Directed bench for mac_lookup_ctrl with a behavioural MAC table attached.
// Stats checks depend on whether MAC_CTRL_STATS_EN is defined for the build.
module tb_mac_lookup_ctrl;

   localparam int PORTS = 4;
   localparam int DEPTH = 1024;
   localparam int PW    = 2;
   localparam int IW    = 10;

   localparam logic [47:0] MAC_A  = 48'h001122334455;
   localparam logic [47:0] MAC_7  = 48'h000000000007;
   localparam logic [47:0] MAC_9  = 48'h000000000009;
   localparam logic [47:0] MAC_C  = 48'h00000000000C;
   localparam logic [47:0] MAC_D  = 48'h00000000000D;
   localparam logic [47:0] MAC_E  = 48'h00000000000E;
   localparam logic [47:0] MAC_F  = 48'h00000000000F;
   localparam logic [47:0] MAC_FF = 48'h0000000000FF;
   localparam logic [47:0] MAC_MC = 48'h01005E000001;
   localparam logic [47:0] BCAST  = 48'hFFFFFFFFFFFF;

   logic            iclk = 1'b0;
   logic            i_rst;
   logic            i_valid;
   logic [7:0]      i_data;
   logic            i_sof;
   logic            i_eof;
   logic [PW-1:0]   i_src_port;
   logic            o_write_enable;
   logic [PW-1:0]   o_port_num;
   logic [IW-1:0]   o_MAC_SA;
   logic [IW-1:0]   o_MAC_DA;
   logic [PW-1:0]   i_table_port;
   logic            o_fwd_valid;
   logic            i_fwd_ready;
   logic [PW-1:0]   o_fwd_port;
   logic            o_fwd_flood;
   logic            o_fwd_filter;
   logic            o_drop;
   logic [15:0]     o_stat_learn;
   logic [15:0]     o_stat_flood;
   logic [15:0]     o_stat_drop;

   int n_cmp = 0;
   int n_bad = 0;
   int we_cnt = 0;
   int drop_cnt = 0;

   logic            issue_we;
   logic [IW-1:0]   issue_sa;
   logic [IW-1:0]   issue_da;
   logic [PW-1:0]   issue_port;

   always #5 iclk = ~iclk;

   mac_lookup_ctrl #(.pPORT_NUM(PORTS), .pMAC_MEM_DEPTH(DEPTH)) dut (
      .iclk           (iclk),
      .i_rst          (i_rst),
      .i_valid        (i_valid),
      .i_data         (i_data),
      .i_sof          (i_sof),
      .i_eof          (i_eof),
      .i_src_port     (i_src_port),
      .o_write_enable (o_write_enable),
      .o_port_num     (o_port_num),
      .o_MAC_SA       (o_MAC_SA),
      .o_MAC_DA       (o_MAC_DA),
      .i_table_port   (i_table_port),
      .o_fwd_valid    (o_fwd_valid),
      .i_fwd_ready    (i_fwd_ready),
      .o_fwd_port     (o_fwd_port),
      .o_fwd_flood    (o_fwd_flood),
      .o_fwd_filter   (o_fwd_filter),
      .o_drop         (o_drop),
      .o_stat_learn   (o_stat_learn),
      .o_stat_flood   (o_stat_flood),
      .o_stat_drop    (o_stat_drop)
   );

   // Behavioural MAC table: registered read, read-before-write.
   logic [PW-1:0] tbl [DEPTH] = '{default: '0};
   logic [PW-1:0] tbl_rd;

   always @(posedge iclk) begin
      if (o_write_enable) tbl[o_MAC_SA] <= o_port_num;
      tbl_rd <= tbl[o_MAC_DA];
   end
   assign i_table_port = tbl_rd;

   always @(negedge iclk) begin
      if (o_write_enable) we_cnt++;
      if (o_drop) drop_cnt++;
   end

   task automatic send_frame(input logic [47:0] da, input logic [47:0] sa,
                             input logic [PW-1:0] port, input int nbytes, input bit eof_last);
      logic [95:0] h;
      h = {da, sa};
      for (int k = 0; k <= nbytes; k++) begin
         @(posedge iclk); #1;
         if (k < nbytes) begin
            i_valid    = 1'b1;
            i_sof      = (k == 0);
            i_eof      = eof_last && (k == nbytes - 1);
            i_src_port = (k == 0) ? port : ~port;
            if (k < 12) i_data = h[95 - 8*k -: 8];
            else        i_data = 8'hA5;
         end else begin
            i_valid = 1'b0;
            i_sof   = 1'b0;
            i_eof   = 1'b0;
            i_data  = 8'h00;
         end
         if (k == 12) begin
            @(negedge iclk);
            issue_we   = o_write_enable;
            issue_sa   = o_MAC_SA;
            issue_da   = o_MAC_DA;
            issue_port = o_port_num;
         end
      end
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_valid = 1'b0; i_data = 8'h00; i_sof = 1'b0; i_eof = 1'b0;
      i_src_port = '0; i_fwd_ready = 1'b1;
      repeat (3) @(posedge iclk);
      #1 i_rst = 1'b0;
      @(negedge iclk);
      n_cmp++;
      if (o_fwd_valid !== 1'b0 || o_write_enable !== 1'b0 || o_drop !== 1'b0) begin
         n_bad++; $display("FAIL reset_strobes: got valid=%b we=%b drop=%b want 0 0 0", o_fwd_valid, o_write_enable, o_drop);
      end
      n_cmp++;
      if ({o_fwd_port, o_fwd_flood, o_fwd_filter, o_port_num, o_MAC_SA, o_MAC_DA} !== '0) begin
         n_bad++; $display("FAIL reset_data: got port=%0d flood=%b filter=%b pn=%0d sa=%h da=%h want all 0",
                           o_fwd_port, o_fwd_flood, o_fwd_filter, o_port_num, o_MAC_SA, o_MAC_DA);
      end
      n_cmp++;
      if ({o_stat_learn, o_stat_flood, o_stat_drop} !== 48'h0) begin
         n_bad++; $display("FAIL reset_stats: got %h %h %h want 0", o_stat_learn, o_stat_flood, o_stat_drop);
      end
   endtask

   task automatic test_reset_midframe();
      int d0;
      send_frame(MAC_7, MAC_E, 2'd1, 5, 1'b0);
      d0 = drop_cnt;
      @(posedge iclk); #1 i_rst = 1'b1;
      @(posedge iclk); #1 i_rst = 1'b0;
      repeat (3) @(negedge iclk);
      send_frame(MAC_7, MAC_F, 2'd0, 12, 1'b1);
      n_cmp++;
      if (issue_we !== 1'b1 || issue_sa !== 10'h00F) begin
         n_bad++; $display("FAIL midreset_learn: got we=%b sa=%h want 1 00f", issue_we, issue_sa);
      end
      repeat (2) @(negedge iclk);
      n_cmp++;
      if (drop_cnt - d0 !== 0) begin
         n_bad++; $display("FAIL midreset_drop: got %0d drops want 0", drop_cnt - d0);
      end
   endtask

   task automatic test_unicast();
      int w0;
      w0 = we_cnt;
      send_frame(MAC_7, MAC_A, 2'd2, 12, 1'b1);
      n_cmp++;
      if (issue_we !== 1'b1 || issue_sa !== 10'h2E3 || issue_da !== 10'h007 || issue_port !== 2'd2) begin
         n_bad++; $display("FAIL uni_issue_a: got we=%b sa=%h da=%h pn=%0d want 1 2e3 007 2", issue_we, issue_sa, issue_da, issue_port);
      end
      @(negedge iclk);
      n_cmp++;
      if (o_fwd_valid !== 1'b0) begin
         n_bad++; $display("FAIL uni_wait_valid: got %b want 0", o_fwd_valid);
      end
      @(negedge iclk);
      n_cmp++;
      if (o_fwd_valid !== 1'b1 || o_fwd_flood !== 1'b0 || o_fwd_filter !== 1'b0) begin
         n_bad++; $display("FAIL uni_decide_a: got valid=%b flood=%b filter=%b want 1 0 0", o_fwd_valid, o_fwd_flood, o_fwd_filter);
      end
      @(negedge iclk);
      n_cmp++;
      if (o_fwd_valid !== 1'b0) begin
         n_bad++; $display("FAIL uni_transfer: got valid=%b want 0", o_fwd_valid);
      end
      send_frame(MAC_A, MAC_9, 2'd1, 12, 1'b1);
      n_cmp++;
      if (issue_sa !== 10'h009 || issue_da !== 10'h2E3 || issue_port !== 2'd1) begin
         n_bad++; $display("FAIL uni_issue_b: got sa=%h da=%h pn=%0d want 009 2e3 1", issue_sa, issue_da, issue_port);
      end
      repeat (2) @(negedge iclk);
      n_cmp++;
      if (o_fwd_valid !== 1'b1 || o_fwd_port !== 2'd2 || o_fwd_flood !== 1'b0 || o_fwd_filter !== 1'b0) begin
         n_bad++; $display("FAIL uni_decide_b: got valid=%b port=%0d flood=%b filter=%b want 1 2 0 0",
                           o_fwd_valid, o_fwd_port, o_fwd_flood, o_fwd_filter);
      end
      n_cmp++;
      if (we_cnt - w0 !== 2) begin
         n_bad++; $display("FAIL uni_we_count: got %0d want 2", we_cnt - w0);
      end
   endtask

   task automatic test_filter();
      send_frame(MAC_9, MAC_D, 2'd1, 12, 1'b1);
      repeat (2) @(negedge iclk);
      n_cmp++;
      if (o_fwd_valid !== 1'b1 || o_fwd_port !== 2'd1 || o_fwd_flood !== 1'b0 || o_fwd_filter !== 1'b1) begin
         n_bad++; $display("FAIL filter: got valid=%b port=%0d flood=%b filter=%b want 1 1 0 1",
                           o_fwd_valid, o_fwd_port, o_fwd_flood, o_fwd_filter);
      end
   endtask

   task automatic test_broadcast();
      send_frame(MAC_7, MAC_FF, 2'd3, 12, 1'b1);
      repeat (2) @(negedge iclk);
      send_frame(BCAST, MAC_C, 2'd3, 12, 1'b1);
      n_cmp++;
      if (issue_we !== 1'b1 || issue_sa !== 10'h00C || issue_da !== 10'h0FF) begin
         n_bad++; $display("FAIL bcast_issue: got we=%b sa=%h da=%h want 1 00c 0ff", issue_we, issue_sa, issue_da);
      end
      repeat (2) @(negedge iclk);
      n_cmp++;
      if (o_fwd_valid !== 1'b1 || o_fwd_port !== 2'd0 || o_fwd_flood !== 1'b1 || o_fwd_filter !== 1'b0) begin
         n_bad++; $display("FAIL bcast_decide: got valid=%b port=%0d flood=%b filter=%b want 1 0 1 0",
                           o_fwd_valid, o_fwd_port, o_fwd_flood, o_fwd_filter);
      end
   endtask

   task automatic test_mcast_sa();
      int w0;
      w0 = we_cnt;
      send_frame(MAC_7, MAC_MC, 2'd0, 12, 1'b1);
      n_cmp++;
      if (issue_we !== 1'b0 || issue_sa !== 10'h1E1) begin
         n_bad++; $display("FAIL mcast_sa_issue: got we=%b sa=%h want 0 1e1", issue_we, issue_sa);
      end
      repeat (2) @(negedge iclk);
      n_cmp++;
      if (o_fwd_valid !== 1'b1 || we_cnt - w0 !== 0) begin
         n_bad++; $display("FAIL mcast_sa_decide: got valid=%b learns=%0d want 1 0", o_fwd_valid, we_cnt - w0);
      end
   endtask

   task automatic test_runt();
      int d0;
      int w0;
      int nval;
      d0 = drop_cnt; w0 = we_cnt; nval = 0;
      send_frame(MAC_7, MAC_E, 2'd0, 8, 1'b1);
      @(negedge iclk);
      n_cmp++;
      if (o_drop !== 1'b1) begin
         n_bad++; $display("FAIL runt_drop_pulse: got %b want 1", o_drop);
      end
      for (int c = 0; c < 6; c++) begin
         @(negedge iclk);
         if (o_fwd_valid) nval++;
      end
      n_cmp++;
      if (nval !== 0 || we_cnt - w0 !== 0 || drop_cnt - d0 !== 1) begin
         n_bad++; $display("FAIL runt_effects: got valid=%0d learns=%0d drops=%0d want 0 0 1", nval, we_cnt - w0, drop_cnt - d0);
      end
   endtask

   task automatic test_restart();
      int d0;
      send_frame(MAC_7, MAC_F, 2'd3, 5, 1'b0);
      d0 = drop_cnt;
      send_frame(MAC_A, MAC_E, 2'd0, 12, 1'b1);
      n_cmp++;
      if (issue_we !== 1'b1 || issue_sa !== 10'h00E || issue_da !== 10'h2E3 || issue_port !== 2'd0) begin
         n_bad++; $display("FAIL restart_issue: got we=%b sa=%h da=%h pn=%0d want 1 00e 2e3 0", issue_we, issue_sa, issue_da, issue_port);
      end
      repeat (2) @(negedge iclk);
      n_cmp++;
      if (o_fwd_valid !== 1'b1 || o_fwd_port !== 2'd2 || drop_cnt - d0 !== 1) begin
         n_bad++; $display("FAIL restart_decide: got valid=%b port=%0d drops=%0d want 1 2 1", o_fwd_valid, o_fwd_port, drop_cnt - d0);
      end
   endtask

   task automatic test_backpressure();
      int d0;
      int bad_hold;
      i_fwd_ready = 1'b0;
      send_frame(MAC_A, MAC_C, 2'd3, 12, 1'b1);
      repeat (2) @(negedge iclk);
      d0 = drop_cnt; bad_hold = 0;
      for (int c = 0; c < 10; c++) begin
         if (o_fwd_valid !== 1'b1 || o_fwd_port !== 2'd2 || o_fwd_flood !== 1'b0 || o_fwd_filter !== 1'b0) bad_hold++;
         i_valid = (c == 3);
         i_sof   = (c == 3);
         i_data  = 8'h00;
         @(negedge iclk);
      end
      i_valid = 1'b0; i_sof = 1'b0;
      n_cmp++;
      if (bad_hold !== 0) begin
         n_bad++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad_hold);
      end
      n_cmp++;
      if (drop_cnt - d0 !== 1) begin
         n_bad++; $display("FAIL bp_drop: got %0d drops want 1", drop_cnt - d0);
      end
      i_fwd_ready = 1'b1;
      @(negedge iclk);
      n_cmp++;
      if (o_fwd_valid !== 1'b0) begin
         n_bad++; $display("FAIL bp_release: got valid=%b want 0", o_fwd_valid);
      end
   endtask

   task automatic test_stats();
`ifdef MAC_CTRL_STATS_EN
      @(posedge iclk); #1 i_rst = 1'b1;
      @(posedge iclk); #1 i_rst = 1'b0;
      i_fwd_ready = 1'b0;
      send_frame(BCAST, MAC_C, 2'd3, 12, 1'b1);
      repeat (2) @(negedge iclk);
      i_valid = 1'b1; i_sof = 1'b1; i_data = 8'h00;
      repeat (70000) @(negedge iclk);
      i_valid = 1'b0; i_sof = 1'b0;
      repeat (2) @(negedge iclk);
      n_cmp++;
      if (o_stat_drop !== 16'hFFFF || o_stat_learn !== 16'd1 || o_stat_flood !== 16'd0) begin
         n_bad++; $display("FAIL stats_sat: got drop=%h learn=%h flood=%h want ffff 0001 0000", o_stat_drop, o_stat_learn, o_stat_flood);
      end
      i_fwd_ready = 1'b1;
      @(negedge iclk);
      n_cmp++;
      if (o_stat_flood !== 16'd1 || o_fwd_valid !== 1'b0) begin
         n_bad++; $display("FAIL stats_flood: got flood=%h valid=%b want 0001 0", o_stat_flood, o_fwd_valid);
      end
`else
      @(negedge iclk);
      n_cmp++;
      if ({o_stat_learn, o_stat_flood, o_stat_drop} !== 48'h0) begin
         n_bad++; $display("FAIL stats_tied: got %h %h %h want 0", o_stat_learn, o_stat_flood, o_stat_drop);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_reset_midframe();
      test_unicast();
      test_filter();
      test_broadcast();
      test_mcast_sa();
      test_runt();
      test_restart();
      test_backpressure();
      test_stats();
      repeat (2) @(negedge iclk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
